// File: rtl/nn_stream_sequencer_if.sv
// Wishbone slave bus bundle for nn_stream_sequencer (32-bit address and data).
interface nn_stream_sequencer_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/nn_stream_sequencer.sv
// Wishbone-mapped NN input sequencer: host words into the input FIFO, LEN-beat framed stream to the MAC.
// Optional feature: define NN_SEQ_IRQ_EN to add irq_o (done & CTRL[4] mask).
module nn_stream_sequencer #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned LEN_W        = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    nn_stream_sequencer_if.slave wb,
    output logic                 fifo_push,
    output logic [DATA_W-1:0]    fifo_din,
    input  logic                 fifo_full,
    output logic                 fifo_pop,
    input  logic [DATA_W-1:0]    fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_flush,
    output logic                 mac_valid,
    output logic [DATA_W-1:0]    mac_data,
    output logic                 mac_first,
    output logic                 mac_last,
    input  logic                 mac_ready,
    input  logic                 res_valid,
    input  logic [31:0]          res_data
`ifdef NN_SEQ_IRQ_EN
    ,
    output logic                 irq_o
`endif
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_RESULT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [31:0]       result_q, result_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              ack_q, ack_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              push_q, push_d;
    logic              flush_q, flush_d;

    logic [31:0]       off_c;
    logic [1:0]        reg_c;
    logic [LEN_W-1:0]  wr_len_c;
    logic              in_map_c, hit_c, wr_c, rd_c, ctrl_wr_c, data_wr_c;
    logic              start_c, abort_c, clr_c, flush_req_c;
    logic              run_c, busy_c, beat_c, last_c, irq_mask_c;
    logic [31:0]       ctrl_rd_c, status_c;
    logic              unused_sel_c;

    // Decode: exactly the four word-aligned registers above BASE_ADDRESS respond
    assign off_c       = wb.wbs_adr_i - BASE_ADDRESS;
    assign in_map_c    = (off_c[31:4] == 28'd0) && (off_c[1:0] == 2'b00);
    assign reg_c       = off_c[3:2];
    assign hit_c       = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q & in_map_c;
    assign wr_c        = hit_c & wb.wbs_we_i;
    assign rd_c        = hit_c & ~wb.wbs_we_i;
    assign ctrl_wr_c   = wr_c & (reg_c == REG_CTRL);
    assign data_wr_c   = wr_c & (reg_c == REG_DATA);
    assign start_c     = ctrl_wr_c & wb.wbs_dat_i[0];
    assign abort_c     = ctrl_wr_c & wb.wbs_dat_i[1];
    assign clr_c       = ctrl_wr_c & wb.wbs_dat_i[2];
    assign flush_req_c = ctrl_wr_c & wb.wbs_dat_i[3];
    assign wr_len_c    = LEN_W'(wb.wbs_dat_i[31:16]);
    assign unused_sel_c = ^wb.wbs_sel_i;

    assign run_c  = (state_q == S_RUN);
    assign busy_c = run_c | (state_q == S_WAIT);
    assign last_c = (count_q == len_q - LEN_W'(1));

    // Stream side follows the FWFT head combinationally so a stalled beat stays put
    assign mac_valid = run_c & ~fifo_empty;
    assign mac_data  = run_c ? fifo_dout : '0;
    assign mac_first = run_c & (count_q == '0);
    assign mac_last  = run_c & last_c;
    assign beat_c    = mac_valid & mac_ready;
    assign fifo_pop  = beat_c;

    assign ctrl_rd_c = {16'(len_q), 11'd0, irq_mask_c, 4'd0};
    assign status_c  = {16'(count_q), 10'd0, fifo_full, fifo_empty, err_q, ovf_q, done_q, busy_c};

    // Next-state: clears are applied first so any same-cycle flag set overrides them
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        count_d  = count_q;
        result_d = result_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        ack_d    = hit_c;
        rdata_d  = '0;
        push_d   = 1'b0;
        din_d    = '0;
        flush_d  = 1'b0;

        if (clr_c) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
            err_d  = 1'b0;
        end

        // LEN is frozen while a vector is in flight
        if (ctrl_wr_c && !busy_c) begin
            len_d = wr_len_c;
        end

        if (abort_c) begin
            state_d = S_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (beat_c) begin
                        count_d = count_q + LEN_W'(1);
                        if (last_c) begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (res_valid) begin
                        result_d = res_data;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end
                default: ;
            endcase

            if (start_c) begin
                if (busy_c || (wr_len_c == '0)) begin
                    err_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                    count_d = '0;
                    done_d  = 1'b0;
                end
            end
        end

        if (flush_req_c) begin
            if (busy_c) begin
                err_d = 1'b1;
            end else begin
                flush_d = 1'b1;
            end
        end

        if (data_wr_c) begin
            if (fifo_full) begin
                ovf_d = 1'b1;
            end else begin
                push_d = 1'b1;
                din_d  = DATA_W'(wb.wbs_dat_i);
            end
        end

        if (rd_c) begin
            case (reg_c)
                REG_CTRL:   rdata_d = ctrl_rd_c;
                REG_STATUS: rdata_d = status_c;
                REG_RESULT: rdata_d = result_q;
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            rdata_q  <= '0;
            din_q    <= '0;
            ack_q    <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            push_q   <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            count_q  <= count_d;
            result_q <= result_d;
            rdata_q  <= rdata_d;
            din_q    <= din_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            push_q   <= push_d;
            flush_q  <= flush_d;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = rdata_q;
    assign fifo_push    = push_q;
    assign fifo_din     = din_q;
    assign fifo_flush   = flush_q;

`ifdef NN_SEQ_IRQ_EN
    logic irq_mask_q, irq_mask_d, irq_q, irq_d;

    // irq follows the next done value, so START and CLR_FLAGS drop it with done
    always_comb begin
        irq_mask_d = ctrl_wr_c ? wb.wbs_dat_i[4] : irq_mask_q;
        irq_d      = done_d & irq_mask_d;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_mask_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end

    assign irq_mask_c = irq_mask_q;
    assign irq_o      = irq_q;
`else
    assign irq_mask_c = 1'b0;
`endif

endmodule

// File: tb/tb_nn_stream_sequencer.sv
// Self-checking bench for nn_stream_sequencer: behavioural FWFT FIFO, expected-word queue, directed steps.
module tb_nn_stream_sequencer;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] O_CTRL = 32'h0, O_STAT = 32'h4, O_DATA = 32'h8, O_RES = 32'hC;
    localparam logic [15:0] B_START = 16'h1, B_ABORT = 16'h2, B_CLR = 16'h4, B_FLUSH = 16'h8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_push, fifo_pop, fifo_flush;
    logic [31:0] fifo_din, mac_data;
    logic        fifo_full = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_dout = '0;
    logic        mac_valid, mac_first, mac_last;
    logic        mac_ready = 1'b0;
    logic        res_valid = 1'b0;
    logic [31:0] res_data = '0;
`ifdef NN_SEQ_IRQ_EN
    logic        irq_o;
`endif

    int checks = 0;
    int errors = 0;
    int pop_cnt = 0, push_cnt = 0, flush_cnt = 0;

    logic [31:0] fq[$];
    logic [31:0] m_q[$];
    logic [31:0] obs_d[$];
    logic        obs_f[$];
    logic        obs_l[$];
    logic        held_v = 1'b0;
    logic [33:0] held = '0;

    nn_stream_sequencer_if wb();

    nn_stream_sequencer dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wb         (wb),
        .fifo_push  (fifo_push),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .fifo_pop   (fifo_pop),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_flush (fifo_flush),
        .mac_valid  (mac_valid),
        .mac_data   (mac_data),
        .mac_first  (mac_first),
        .mac_last   (mac_last),
        .mac_ready  (mac_ready),
        .res_valid  (res_valid),
        .res_data   (res_data)
`ifdef NN_SEQ_IRQ_EN
        ,
        .irq_o      (irq_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // First-word-fall-through FIFO standing in for fifo_buffer
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || fifo_flush) begin
            fq.delete();
        end else begin
            if (fifo_pop && fq.size() != 0) void'(fq.pop_front());
            if (fifo_push && fq.size() < DEPTH) fq.push_back(fifo_din);
        end
        fifo_empty <= (fq.size() == 0);
        fifo_full  <= (fq.size() >= DEPTH);
        fifo_dout  <= (fq.size() != 0) ? fq[0] : 32'h0;
    end

    // Beat log, strobe counters and hold-while-stalled check
    always @(posedge clk) begin
        if (rst_n) begin
            if (held_v && mac_valid) begin
                chk("hold_data", mac_data, held[33:2]);
                chk("hold_flags", 32'({mac_first, mac_last}), 32'(held[1:0]));
            end
            if (mac_valid && mac_ready) begin
                obs_d.push_back(mac_data);
                obs_f.push_back(mac_first);
                obs_l.push_back(mac_last);
            end
            if (fifo_pop)   pop_cnt++;
            if (fifo_push)  push_cnt++;
            if (fifo_flush) flush_cnt++;
        end
        held_v = rst_n && mac_valid && !mac_ready;
        held   = {mac_data, mac_first, mac_last};
    end

    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic acked);
        @(negedge clk);
        wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_adr_i = adr;  wb.wbs_dat_i = wd;
        acked = 1'b0; rd = '0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(negedge clk);
            if (wb.wbs_ack_o) begin
                acked = 1'b1;
                rd = wb.wbs_dat_o;
            end
        end
        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        logic [31:0] rd; logic a;
        bus(1'b1, BASE + off, data, rd, a);
        chk("wr_ack", 32'(a), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] rd; logic a;
        bus(1'b0, BASE + off, 32'h0, rd, a);
        chk("rd_ack", 32'(a), 32'd1);
        chk(tag, rd, exp);
    endtask

    task automatic push_word(input logic [31:0] w);
        wr(O_DATA, w);
        m_q.push_back(w);
    endtask

    function automatic logic [31:0] cw(input int len, input logic [15:0] bits);
        return {16'(len), bits};
    endfunction

    function automatic logic [31:0] st(input int cnt, input bit busy, input bit done, input bit ovf,
                                       input bit err, input bit empty, input bit full);
        return {16'(cnt), 10'd0, full, empty, err, ovf, done, busy};
    endfunction

    task automatic wait_beats(input int n);
        for (int i = 0; i < 100 && obs_d.size() < n; i++) @(negedge clk);
        chk("beat_count", 32'(obs_d.size()), 32'(n));
    endtask

    // Beats [from,to) must be the next queued host words, framed against LEN
    task automatic compare_beats(input int from, input int to, input int len);
        for (int b = from; b < to; b++) begin
            if (b < obs_d.size() && m_q.size() != 0) begin
                chk("beat_data", obs_d[b], m_q.pop_front());
                chk("beat_first", 32'(obs_f[b]), 32'(b == 0));
                chk("beat_last", 32'(obs_l[b]), 32'(b == len - 1));
            end
        end
    endtask

    task automatic result_pulse(input logic [31:0] v);
        @(negedge clk); res_valid = 1'b1; res_data = v;
        @(negedge clk); res_valid = 1'b0;
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_ack"}, 32'(wb.wbs_ack_o), 32'd0);
        chk({tag, "_dat"}, wb.wbs_dat_o, 32'd0);
        chk({tag, "_strobes"}, 32'({fifo_push, fifo_pop, fifo_flush}), 32'd0);
        chk({tag, "_mac"}, 32'({mac_valid, mac_first, mac_last}), 32'd0);
        chk({tag, "_mac_data"}, mac_data, 32'd0);
        chk({tag, "_din"}, fifo_din, 32'd0);
    endtask

    initial begin
        logic [31:0] rd, w, r;
        logic        a;
        int          snap;

        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = '0;   wb.wbs_dat_i = '0;

        // Reset values
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        rst_n = 1'b1;
        rd_chk("status_reset", O_STAT, st(0, 0, 0, 0, 0, 1, 0));
        rd_chk("ctrl_reset", O_CTRL, 32'h0);
        rd_chk("result_reset", O_RES, 32'h0);
        bus(1'b0, BASE + 32'h10, 32'h0, rd, a);
        chk("unmapped_no_ack", 32'(a), 32'd0);

        // Four words, LEN=4, ready held high
        mac_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word($urandom);
        obs_d.delete(); obs_f.delete(); obs_l.delete();
        wr(O_CTRL, cw(4, B_START));
        wait_beats(4);
        compare_beats(0, 4, 4);
        @(negedge clk);
        chk("valid_low_in_wait", 32'(mac_valid), 32'd0);
        rd_chk("status_wait", O_STAT, st(4, 1, 0, 0, 0, 1, 0));
        rd_chk("ctrl_len4", O_CTRL, cw(4, 16'h0));
        result_pulse(32'h55);
        rd_chk("result_55", O_RES, 32'h55);
        rd_chk("status_done", O_STAT, st(4, 0, 1, 0, 0, 1, 0));
        result_pulse(32'h77);
        rd_chk("result_ignored", O_RES, 32'h55);

        // LEN=3 with the FIFO starved after the first word
        push_word($urandom);
        obs_d.delete(); obs_f.delete(); obs_l.delete();
        wr(O_CTRL, cw(3, B_START));
        repeat (10) @(negedge clk);
        chk("starved_beats", 32'(obs_d.size()), 32'd1);
        chk("starved_valid", 32'(mac_valid), 32'd0);
        rd_chk("status_starved", O_STAT, st(1, 1, 0, 0, 0, 1, 0));
        push_word($urandom);
        push_word($urandom);
        wait_beats(3);
        compare_beats(0, 3, 3);
        r = $urandom;
        result_pulse(r);
        rd_chk("result_rand", O_RES, r);

        // mac_ready toggling 1,0,1,0
        mac_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word($urandom);
        obs_d.delete(); obs_f.delete(); obs_l.delete();
        snap = pop_cnt;
        wr(O_CTRL, cw(3, B_START));
        for (int i = 0; i < 40 && obs_d.size() < 3; i++) begin
            @(negedge clk);
            mac_ready = ~mac_ready;
        end
        mac_ready = 1'b0;
        wait_beats(3);
        compare_beats(0, 3, 3);
        chk("toggle_pops", 32'(pop_cnt - snap), 32'd3);
        rd_chk("status_toggle", O_STAT, st(3, 1, 0, 0, 0, 1, 0));
        result_pulse(32'hA5A5_0001);

        // Fill to full, overflow write, clear, flush
        for (int i = 0; i < DEPTH; i++) push_word($urandom);
        rd_chk("status_full", O_STAT, st(3, 0, 1, 0, 0, 0, 1));
        snap = push_cnt;
        wr(O_DATA, 32'hDEAD);
        @(negedge clk);
        chk("ovf_no_push", 32'(push_cnt - snap), 32'd0);
        rd_chk("status_ovf", O_STAT, st(3, 0, 1, 1, 0, 0, 1));
        wr(O_CTRL, cw(3, B_CLR));
        rd_chk("status_clr", O_STAT, st(3, 0, 0, 0, 0, 0, 1));
        snap = flush_cnt;
        wr(O_CTRL, cw(3, B_FLUSH));
        @(negedge clk);
        chk("flush_pulse", 32'(flush_cnt - snap), 32'd1);
        m_q.delete();
        rd_chk("status_flushed", O_STAT, st(3, 0, 0, 0, 0, 1, 0));

        // LEN=5: two beats, illegal START/FLUSH, one more beat, ABORT
        for (int i = 0; i < 5; i++) push_word($urandom);
        obs_d.delete(); obs_f.delete(); obs_l.delete();
        wr(O_CTRL, cw(5, B_START));
        mac_ready = 1'b1;
        repeat (2) @(negedge clk);
        mac_ready = 1'b0;
        chk("two_beats", 32'(obs_d.size()), 32'd2);
        compare_beats(0, 2, 5);
        wr(O_CTRL, cw(5, B_START));
        rd_chk("status_start_busy", O_STAT, st(2, 1, 0, 0, 1, 0, 0));
        wr(O_CTRL, cw(5, B_CLR));
        rd_chk("status_clr_busy", O_STAT, st(2, 1, 0, 0, 0, 0, 0));
        snap = flush_cnt;
        wr(O_CTRL, cw(5, B_FLUSH));
        rd_chk("status_flush_busy", O_STAT, st(2, 1, 0, 0, 1, 0, 0));
        chk("flush_blocked", 32'(flush_cnt - snap), 32'd0);
        mac_ready = 1'b1;
        @(negedge clk);
        mac_ready = 1'b0;
        chk("third_beat", 32'(obs_d.size()), 32'd3);
        compare_beats(2, 3, 5);
        wr(O_CTRL, cw(5, B_ABORT));
        chk("abort_valid", 32'(mac_valid), 32'd0);
        snap = pop_cnt;
        mac_ready = 1'b1;
        repeat (5) @(negedge clk);
        mac_ready = 1'b0;
        chk("abort_no_pops", 32'(pop_cnt - snap), 32'd0);
        rd_chk("status_abort", O_STAT, st(0, 0, 0, 0, 1, 0, 0));
        wr(O_CTRL, cw(0, B_CLR));
        wr(O_CTRL, cw(0, B_START));
        rd_chk("status_len0", O_STAT, st(0, 0, 0, 0, 1, 0, 0));
        rd_chk("ctrl_len0", O_CTRL, 32'h0);
        wr(O_CTRL, cw(5, B_ABORT | B_START));
        rd_chk("status_abort_wins", O_STAT, st(0, 0, 0, 0, 1, 0, 0));
        rd_chk("ctrl_len5", O_CTRL, cw(5, 16'h0));

        // Reset while waiting for a result
        obs_d.delete(); obs_f.delete(); obs_l.delete();
        mac_ready = 1'b1;
        wr(O_CTRL, cw(1, B_START));
        wait_beats(1);
        compare_beats(0, 1, 1);
        rd_chk("status_wait1", O_STAT, st(1, 1, 0, 0, 1, 0, 0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        outputs_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        m_q.delete();
        rd_chk("status_after_reset", O_STAT, 32'h0000_0010);
        rd_chk("result_after_reset", O_RES, 32'h0);
        rd_chk("ctrl_after_reset", O_CTRL, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
